// File: rtl/types_pkg.sv
// Shared widths and FSM state encoding for the scratchpad-to-memory bridge.
package types_pkg;

    localparam int WORD_W       = 16;  // word address width
    localparam int ROW_S_W      = 4;   // scratchpad row index width
    localparam int BITS_PER_ROW = 32;  // row data width on the memory side

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/sp_mem_bridge_if.sv
// Memory-side request/response bus of the scratchpad bridge.
// master = bridge (issues requests), slave = memory (answers them).
interface sp_mem_bridge_if;
    import types_pkg::*;

    logic                    mem_ren;
    logic                    mem_wen;
    logic [WORD_W-1:0]       mem_addr;
    logic [BITS_PER_ROW-1:0] mem_wdata;
    logic                    mem_ready;
    logic                    mem_rvalid;
    logic [BITS_PER_ROW-1:0] mem_rdata;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/sp_mem_bridge.sv
// Scratchpad load/store bridge to a single-outstanding memory port.
// Loads take priority over stores; one transaction in flight at a time.
// Optional feature macro SP_MEM_TIMEOUT_EN: aborts a stuck transaction after
// TIMEOUT_CYC cycles, returns zero read data and raises sticky mem_err.
module sp_mem_bridge
    import types_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    sLoad,
    input  logic [WORD_W-1:0]       load_addr,
    input  logic                    sStore,
    input  logic [WORD_W-1:0]       store_addr,
    input  logic [BITS_PER_ROW-1:0] store_data,
    output logic                    sLoad_hit,
    output logic [ROW_S_W-1:0]      sLoad_row,
    output logic [BITS_PER_ROW-2:0] load_data,
    output logic                    sStore_hit,
    sp_mem_bridge_if.master         mem,
    output logic                    mem_err
);

    state_e                  state_q, state_d;
    logic [WORD_W-1:0]       addr_q, addr_d;
    logic [BITS_PER_ROW-1:0] wdata_q, wdata_d;
    logic                    is_load_q, is_load_d;
    logic [BITS_PER_ROW-2:0] ldata_q, ldata_d;
    logic [ROW_S_W-1:0]      row_q, row_d;

    // Top bit of the read row is not returned to the scratchpad.
    logic unused_rdata_msb;
    assign unused_rdata_msb = mem.mem_rdata[BITS_PER_ROW-1];

`ifdef SP_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             busy;
    assign busy = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    // Next-state: capture request in IDLE, follow memory handshake, one-cycle DONE.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_load_d = is_load_q;
        ldata_d   = ldata_q;
        row_d     = row_q;
        case (state_q)
            IDLE: begin
                if (sLoad) begin
                    state_d   = RD_REQ;
                    addr_d    = load_addr;
                    is_load_d = 1'b1;
                end else if (sStore) begin
                    state_d   = WR_REQ;
                    addr_d    = store_addr;
                    wdata_d   = store_data;
                    is_load_d = 1'b0;
                end
            end
            RD_REQ: begin
                if (mem.mem_ready) begin
                    if (mem.mem_rvalid) begin
                        state_d = DONE;
                        ldata_d = mem.mem_rdata[BITS_PER_ROW-2:0];
                        row_d   = addr_q[ROW_S_W-1:0];
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (mem.mem_rvalid) begin
                    state_d = DONE;
                    ldata_d = mem.mem_rdata[BITS_PER_ROW-2:0];
                    row_d   = addr_q[ROW_S_W-1:0];
                end
            end
            WR_REQ: begin
                if (mem.mem_ready) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef SP_MEM_TIMEOUT_EN
        // A normal completion in the final allowed cycle wins over the abort.
        cnt_d = cnt_q;
        err_d = err_q;
        if (!busy) begin
            cnt_d = '0;
        end else if (state_d != DONE) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                state_d = DONE;
                err_d   = 1'b1;
                if (is_load_q) begin
                    ldata_d = '0;
                    row_d   = addr_q[ROW_S_W-1:0];
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    // State and captured-request registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_load_q <= 1'b0;
            ldata_q   <= '0;
            row_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_load_q <= is_load_d;
            ldata_q   <= ldata_d;
            row_q     <= row_d;
        end
    end

`ifdef SP_MEM_TIMEOUT_EN
    // Timeout counter and sticky error flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign mem.mem_ren   = (state_q == RD_REQ);
    assign mem.mem_wen   = (state_q == WR_REQ);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign sLoad_hit     = (state_q == DONE) &&  is_load_q;
    assign sStore_hit    = (state_q == DONE) && !is_load_q;
    assign load_data     = ldata_q;
    assign sLoad_row     = row_q;

endmodule

// File: tb/tb_sp_mem_bridge.sv
// Bench for sp_mem_bridge: table vectors, hand-written corner sequences and
// randomized transactions against a latency/data reference model.
module tb_sp_mem_bridge;
    import types_pkg::*;

    localparam int TO_CYC = 8;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    sLoad, sStore;
    logic [WORD_W-1:0]       load_addr, store_addr;
    logic [BITS_PER_ROW-1:0] store_data;
    logic                    sLoad_hit, sStore_hit, mem_err;
    logic [ROW_S_W-1:0]      sLoad_row;
    logic [BITS_PER_ROW-2:0] load_data;

    sp_mem_bridge_if mem_if();

    sp_mem_bridge #(.TIMEOUT_CYC(TO_CYC)) dut (
        .CLK(CLK), .RST(RST),
        .sLoad(sLoad), .load_addr(load_addr),
        .sStore(sStore), .store_addr(store_addr), .store_data(store_data),
        .sLoad_hit(sLoad_hit), .sLoad_row(sLoad_row), .load_data(load_data),
        .sStore_hit(sStore_hit), .mem(mem_if), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Memory responder: accepts after cfg_rdy wait cycles, read data cfg_rv cycles later.
    int          cfg_rdy = 0, cfg_rv = 0;
    logic [31:0] cfg_rdata = '0;
    bit          both_seen = 0;

    initial begin
        int  waited, rwait;
        bit  rd_pend;
        waited = 0; rwait = 0; rd_pend = 0;
        mem_if.mem_ready = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
        forever begin
            @(negedge CLK);
            if (mem_if.mem_ren && mem_if.mem_wen) both_seen = 1;
            mem_if.mem_ready  = 1'b0;
            mem_if.mem_rvalid = 1'b0;
            mem_if.mem_rdata  = $urandom;
            if (RST) begin
                waited = 0; rd_pend = 0;
            end else if (rd_pend) begin
                rwait++;
                if (rwait == cfg_rv) begin
                    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = cfg_rdata; rd_pend = 0;
                end
            end else if (mem_if.mem_ren || mem_if.mem_wen) begin
                waited++;
                if (waited == cfg_rdy + 1) begin
                    mem_if.mem_ready = 1'b1; waited = 0;
                    if (mem_if.mem_ren) begin
                        if (cfg_rv == 0) begin
                            mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = cfg_rdata;
                        end else begin
                            rd_pend = 1; rwait = 0;
                        end
                    end
                end
            end else begin
                waited = 0;
            end
        end
    end

    // Reference model state: last returned load and the sticky error.
    logic [30:0] m_ld  = '0;
    logic [3:0]  m_row = '0;
    bit          m_err = 0;

    task automatic chk_reset_outs(input string tag);
        chk({tag, " ctl"}, 64'({sLoad_hit, sStore_hit, mem_if.mem_ren, mem_if.mem_wen, mem_err}), 64'd0);
        chk({tag, " addr"}, 64'(mem_if.mem_addr), 64'd0);
        chk({tag, " wdata"}, 64'(mem_if.mem_wdata), 64'd0);
        chk({tag, " ldata"}, 64'(load_data), 64'd0);
        chk({tag, " row"}, 64'(sLoad_row), 64'd0);
    endtask

    // One request, held until its hit; inputs scrambled after capture.
    task automatic run_txn(input bit ld, input logic [15:0] addr, input logic [31:0] data,
                           input int rdy, input int rv, input int exp_lat, input int exp_busy,
                           input logic [30:0] exp_ld, input logic [3:0] exp_row, input string tag);
        int n, busy;
        bit got, wrong, stable;
        cfg_rdy = rdy; cfg_rv = rv; cfg_rdata = data;
        if (ld) begin sLoad = 1'b1; load_addr = addr; end
        else begin sStore = 1'b1; store_addr = addr; store_data = data; end
        n = 0; busy = 0; got = 0; wrong = 0; stable = 1;
        while (!got && n < 300) begin
            @(negedge CLK);
            n++;
            if (mem_if.mem_ren || mem_if.mem_wen) begin
                busy++;
                if (mem_if.mem_ren != ld || mem_if.mem_addr != addr || (!ld && mem_if.mem_wdata != data))
                    stable = 0;
            end
            if (ld ? sStore_hit : sLoad_hit) wrong = 1;
            if (ld ? sLoad_hit : sStore_hit) got = 1;
            else begin
                load_addr = 16'($urandom); store_addr = 16'($urandom); store_data = $urandom;
            end
        end
        sLoad = 1'b0; sStore = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " busy cycles"}, 64'(busy), 64'(exp_busy));
        chk({tag, " bus stable"}, 64'(stable), 64'd1);
        chk({tag, " wrong hit"}, 64'(wrong), 64'd0);
        chk({tag, " load_data"}, 64'(load_data), 64'(exp_ld));
        chk({tag, " row"}, 64'(sLoad_row), 64'(exp_row));
        chk({tag, " mem_err"}, 64'(mem_err), 64'(m_err));
        @(negedge CLK);
        chk({tag, " hit one cycle"}, 64'({sLoad_hit, sStore_hit}), 64'd0);
    endtask

    typedef struct {
        bit          ld;
        logic [15:0] addr;
        logic [31:0] data;
        int          rdy, rv, lat, busy;
        logic [30:0] ldat;
        logic [3:0]  row;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   lh, sh, lcnt, hits, rens;
        bit   ov, hit_seen;

        tbl[0] = '{1'b1, 16'h0013, 32'h0000_00A5, 0, 1, 3, 1, 31'h0000_00A5, 4'h3};
        tbl[1] = '{1'b0, 16'h0020, 32'hDEAD_BEEF, 3, 0, 5, 4, 31'h0000_00A5, 4'h3};
        tbl[2] = '{1'b1, 16'h00FF, 32'hFFFF_FFFF, 0, 0, 2, 1, 31'h7FFF_FFFF, 4'hF};
        tbl[3] = '{1'b1, 16'hABC4, 32'h8000_0001, 2, 2, 6, 3, 31'h0000_0001, 4'h4};
        tbl[4] = '{1'b0, 16'h1234, 32'h0000_0000, 0, 0, 2, 1, 31'h0000_0001, 4'h4};
        tbl[5] = '{1'b1, 16'h0000, 32'h1234_5678, 1, 3, 6, 2, 31'h1234_5678, 4'h0};

        RST = 1'b1; sLoad = 1'b0; sStore = 1'b0;
        load_addr = '0; store_addr = '0; store_data = '0;
        repeat (2) @(negedge CLK);
        chk_reset_outs("reset");
        RST = 1'b0;

        // Table vectors; the first request goes out on the first edge after reset.
        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i].ld, tbl[i].addr, tbl[i].data, tbl[i].rdy, tbl[i].rv,
                    tbl[i].lat, tbl[i].busy, tbl[i].ldat, tbl[i].row, $sformatf("vec%0d", i));
            m_ld = tbl[i].ldat; m_row = tbl[i].row;
        end

        // Load and store raised together: read first, then write, never overlapping.
        cfg_rdy = 0; cfg_rv = 0; cfg_rdata = 32'hCAFE_0001;
        sLoad = 1'b1; load_addr = 16'h0102;
        sStore = 1'b1; store_addr = 16'h0203; store_data = 32'h0BAD_F00D;
        lh = 0; sh = 0; lcnt = 0; ov = 0;
        for (int n = 1; n <= 40 && sh == 0; n++) begin
            @(negedge CLK);
            if (sLoad_hit && sStore_hit) ov = 1;
            if (sLoad_hit) begin lh = n; lcnt++; sLoad = 1'b0; end
            if (sStore_hit) begin sh = n; sStore = 1'b0; end
        end
        chk("both load hit cycle", 64'(lh), 64'd2);
        chk("both store hit cycle", 64'(sh), 64'd5);
        chk("both overlap", 64'(ov), 64'd0);
        chk("both load hits", 64'(lcnt), 64'd1);
        chk("both load_data", 64'(load_data), 64'h4AFE_0001);
        m_ld = 31'h4AFE_0001; m_row = 4'h2;
        @(negedge CLK);

        // Load held high through DONE: one memory read per hit, back to back.
        cfg_rdy = 0; cfg_rv = 0; cfg_rdata = 32'h0000_0777;
        sLoad = 1'b1; load_addr = 16'h0009;
        hits = 0; rens = 0;
        repeat (12) begin
            @(negedge CLK);
            if (sLoad_hit) hits++;
            if (mem_if.mem_ren) rens++;
        end
        sLoad = 1'b0;
        chk("hold hits", 64'(hits), 64'd4);
        chk("hold reads", 64'(rens), 64'd4);
        m_ld = 31'h0000_0777; m_row = 4'h9;
        @(negedge CLK);

`ifdef SP_MEM_TIMEOUT_EN
        // Memory never accepts: abort after TO_CYC waiting cycles.
        m_err = 1;
        run_txn(1'b1, 16'h0047, 32'h5555_5555, 100000, 0, TO_CYC + 1, TO_CYC,
                31'h0, 4'h7, "timeout rd");
        m_ld = '0; m_row = 4'h7;
        run_txn(1'b0, 16'h0050, 32'h0101_0101, 1, 0, 3, 2, m_ld, m_row, "after timeout wr");
`endif

        // Asynchronous reset while a read waits for data.
        cfg_rdy = 0; cfg_rv = 50; cfg_rdata = 32'h0000_0BBB;
        sLoad = 1'b1; load_addr = 16'h0031;
        repeat (3) @(negedge CLK);
        chk("pre-reset in flight", 64'({mem_if.mem_ren, sLoad_hit}), 64'd0);
        RST = 1'b1;
        #1;
        chk_reset_outs("mid reset");
        hit_seen = 0;
        repeat (2) begin @(negedge CLK); if (sLoad_hit) hit_seen = 1; end
        sLoad = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        m_ld = '0; m_row = '0; m_err = 0;
        @(negedge CLK);
        if (sLoad_hit) hit_seen = 1;
        chk("no hit after abort", 64'(hit_seen), 64'd0);
        run_txn(1'b1, 16'h0035, 32'h0000_0C3C, 0, 1, 3, 1, 31'h0000_0C3C, 4'h5, "post reset rd");
        m_ld = 31'h0000_0C3C; m_row = 4'h5;

        // Randomized traffic against the latency/data model.
        for (int i = 0; i < 30; i++) begin
            bit          r_ld;
            logic [15:0] r_addr;
            logic [31:0] r_data;
            int          r_rdy, r_rv, e_lat;
            r_ld   = 1'($urandom_range(0, 1));
            r_addr = 16'($urandom);
            r_data = $urandom;
            r_rdy  = $urandom_range(0, 3);
            r_rv   = $urandom_range(0, 3);
            e_lat  = r_ld ? 2 + r_rdy + r_rv : 2 + r_rdy;
            if (r_ld) begin m_ld = r_data[30:0]; m_row = r_addr[3:0]; end
            run_txn(r_ld, r_addr, r_data, r_rdy, r_rv, e_lat, r_rdy + 1, m_ld, m_row,
                    $sformatf("rnd%0d", i));
        end

        chk("ren/wen exclusive", 64'(both_seen), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sp_mem_bridge.md
SP_MEM_BRIDGE -- requirements
Module: sp_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: max cycles an outstanding memory transaction may take before abort (used only with SP_MEM_TIMEOUT_EN).
REQ-002 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sLoad  input  1  scratchpad load request, held until sLoad_hit.
REQ-005 SHALL have port load_addr  input  WORD_W  load word address.
REQ-006 SHALL have port sStore  input  1  scratchpad store request, held until sStore_hit.
REQ-007 SHALL have port store_addr  input  WORD_W  store word address.
REQ-008 SHALL have port store_data  input  BITS_PER_ROW  store row data.
REQ-009 SHALL have port sLoad_hit  output  1  one-cycle load-complete pulse.
REQ-010 SHALL have port sLoad_row  output  ROW_S_W  row index of returned load.
REQ-011 SHALL have port load_data  output  BITS_PER_ROW-1  returned load data.
REQ-012 SHALL have port sStore_hit  output  1  one-cycle store-complete pulse.
REQ-013 SHALL have ports mem_ren, mem_wen  output  1 each  memory read/write request, held until mem_ready.
REQ-014 SHALL have ports mem_addr  output  WORD_W; mem_wdata  output  BITS_PER_ROW.
REQ-015 SHALL have ports mem_ready  input  1  request accepted; mem_rvalid  input  1  read data valid; mem_rdata  input  BITS_PER_ROW.
REQ-016 SHALL have port mem_err  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
REQ-018 IDLE: sLoad=1 -> RD_REQ capturing load_addr and row=load_addr[ROW_S_W-1:0]; else sStore=1 -> WR_REQ capturing store_addr/store_data; both high -> load wins, store stays pending.
REQ-019 RD_REQ: mem_ren=1, mem_addr=captured addr; mem_ready=1 -> RD_WAIT; mem_ready and mem_rvalid same cycle -> DONE with that data.
REQ-020 RD_WAIT: mem_rvalid=1 -> DONE, registering load_data=mem_rdata[BITS_PER_ROW-2:0], sLoad_row=captured row.
REQ-021 WR_REQ: mem_wen=1, mem_addr/mem_wdata from captured values; mem_ready=1 -> DONE.
REQ-022 DONE: exactly one cycle; sLoad_hit or sStore_hit =1 per completed type; requests ignored; -> IDLE.
REQ-023 Minimum latency: request sampled edge k, mem_ready=1 and rvalid immediate -> hit at cycle k+2.
REQ-024 mem_ren and mem_wen SHALL never both be 1; at most one transaction outstanding.
REQ-025 Captured address/data SHALL not change while a transaction is outstanding even if inputs change.
REQ-026 load_data and sLoad_row SHALL hold last value outside DONE.

Reset
REQ-027 RST=1 at any time SHALL force IDLE and all outputs to 0 (mem_err included), aborting any in-flight transaction without a hit pulse.
REQ-028 First request SHALL be sampled on the first rising edge after RST deasserts.

Configuration
REQ-029 Macro SP_MEM_TIMEOUT_EN defined: counter runs in RD_REQ/RD_WAIT/WR_REQ, cleared on entry; reaching TIMEOUT_CYC -> DONE, hit pulse of pending type, load_data=0 for reads, mem_err set sticky until reset.
REQ-030 Macro undefined: no counter, FSM waits indefinitely, mem_err tied 0.

Structure
REQ-031 WORD_W, ROW_S_W, BITS_PER_ROW and the FSM state enum SHALL live in types_pkg.
REQ-032 No sub-module; timeout counter inline under the macro.

Verification
REQ-033 sLoad=1, load_addr=0x13, mem_ready=1, rvalid next cycle with rdata=0xA5 -> sLoad_hit one cycle, load_data=0xA5, sLoad_row=0x13 masked to ROW_S_W.
REQ-034 sStore=1, store_addr=0x20, mem_ready low 3 cycles -> mem_wen held 4 cycles with stable addr/data, sStore_hit once after acceptance.
REQ-035 sLoad and sStore high together -> read serviced first, then write; hits in that order, never overlapping.
REQ-036 RST pulsed during RD_WAIT -> outputs 0, no sLoad_hit, next sLoad serviced normally.
REQ-037 With SP_MEM_TIMEOUT_EN, TIMEOUT_CYC=8, mem_ready stuck 0 -> hit after 8 cycles, load_data=0, mem_err=1 until RST.
REQ-038 Requests held high through DONE -> exactly one transaction per completed hit, no duplicate issue.
